pixel_write_responder: RTL and testbench
========================================

Name: pixel_write_responder

Overview:
- Memory-side end of the Draw / Pixel_Address / Color / Write_Finish handshake driven by the line-drawing circuits.
- Accepts one pixel-write request at a time, bounds-checks the address against the pixel buffer window, and performs a 16-bit Avalon-MM master write.
- Returns a one-cycle Write_Finish acknowledge per request.
- Sits between the drawing circuits and the SDRAM/SRAM pixel-buffer interconnect.

Parameters:
- BUF_BASE, 32'h0800_0000, byte address of the first pixel-buffer word.
- BUF_BYTES, 32'd153600, pixel-buffer size in bytes (320x240x2). Window is [BUF_BASE, BUF_BASE+BUF_BYTES).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- Draw  in  1  request level from drawing circuit
- Pixel_Address  in  32  byte address of pixel, valid while Draw=1
- Color  in  16  RGB565 pixel value, valid while Draw=1
- Write_Finish  out  1  one-cycle acknowledge of the current request
- avm_address  out  32  Avalon write address
- avm_write  out  1  Avalon write strobe
- avm_writedata  out  16  Avalon write data
- avm_byteenable  out  2  constant 2'b11
- avm_waitrequest  in  1  Avalon slave stall
- Busy  out  1  1 in any state other than IDLE
- Pixels_Written  out  CNT_W  count of completed bus writes
- Pixels_Dropped  out  CNT_W  count of out-of-window requests acknowledged without a bus write

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. All registers are cleared on a clk edge with reset=1.
- Reset values: state=IDLE, Write_Finish=0, avm_write=0, avm_address=0, avm_writedata=0, Busy=0, both counters=0.
- States are IDLE, WRITE, FINISH.
- IDLE, Draw=0: stay in IDLE.
- IDLE, Draw=1: at this edge, latch Pixel_Address and Color into addr_q / data_q.
  - If addr_q is in the window and even-aligned, go to WRITE.
  - Otherwise go to FINISH with drop flag set.
- Window test uses unsigned 33-bit arithmetic: in window iff addr >= BUF_BASE and addr - BUF_BASE < BUF_BYTES. An odd address counts as out of window.
- WRITE:
  - avm_write=1, avm_address=addr_q, avm_writedata=data_q.
  - All three are held stable while avm_waitrequest=1.
  - On an edge with avm_waitrequest=0: go to FINISH and increment Pixels_Written.
  - There is no timeout.
- FINISH:
  - Write_Finish=1 for exactly this one cycle. avm_write=0.
  - Go to IDLE.
  - If the drop flag is set, increment Pixels_Dropped and clear the flag.
- Request consumption: a request is consumed at the edge ending FINISH. If Draw is still 1 in the following IDLE cycle, that is a new request: the requester has advanced its address/colour on Write_Finish.
  - Minimum request-to-request period is 3 cycles for a write with no stalls (IDLE, WRITE, FINISH), and 2 cycles for a dropped pixel.
- Latency: a request sampled in IDLE at edge N produces avm_write=1 in cycle N+1. With zero wait states, Write_Finish=1 in cycle N+2.
- Input changes: changes on Pixel_Address/Color after the latch edge are ignored until the next IDLE sample. Draw falling mid-transaction does not abort the write; Write_Finish is still pulsed.
- Counters saturate at all-ones and do not wrap.
- Write_Finish and avm_write are never 1 in the same cycle.
- Reset during WRITE: the bus write is abandoned. avm_write=0 from the cycle after the reset edge. No Write_Finish is issued, and counters are cleared.
- Busy is decoded from state: 1 in WRITE and in FINISH.

Test Plan:
- Single in-window write, waitrequest=0:
  - Stimulus: Draw=1, Pixel_Address=32'h0800_0010, Color=16'hF800.
  - Response: next cycle avm_write=1, address 0800_0010, data F800; following cycle Write_Finish=1; Pixels_Written=1.
- Wait-state stall:
  - Stimulus: same request with avm_waitrequest=1 for 4 cycles.
  - Response: avm_write held with stable address/data for 5 cycles total; Write_Finish exactly once, in the cycle after waitrequest falls.
- Out-of-window and odd addresses:
  - Stimulus: Pixel_Address=32'h0802_5800 (=BASE+BUF_BYTES), then 32'h0800_0003.
  - Response: no avm_write either time; Write_Finish after 1 cycle each; Pixels_Dropped=2; Pixels_Written unchanged.
- Back-to-back stream:
  - Stimulus: Draw held at 1 with address stepping by 2 on each Write_Finish, 10 pixels, no stalls.
  - Response: exactly 10 avm_write transactions at consecutive addresses with matching data, 10 Write_Finish pulses, 30 cycles total.
- Reset mid-write:
  - Stimulus: assert reset for 1 cycle while in WRITE with waitrequest=1.
  - Response: avm_write=0, Busy=0, counters=0 after that edge; no Write_Finish; the next request behaves normally.
- Counter saturation:
  - Stimulus: CNT_W=4, 17 successful writes.
  - Response: Pixels_Written stays at 4'hF.

Source files
------------

// File: rtl/pixel_write_responder.sv
// Memory-side responder for the Draw / Write_Finish pixel handshake.
// Bounds-checks each request, then issues a single 16-bit Avalon-MM write or drops it.
module pixel_write_responder #(
    parameter logic [31:0] BUF_BASE  = 32'h0800_0000,
    parameter logic [31:0] BUF_BYTES = 32'd153600,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Draw,
    input  logic [31:0]      Pixel_Address,
    input  logic [15:0]      Color,
    output logic             Write_Finish,
    output logic [31:0]      avm_address,
    output logic             avm_write,
    output logic [15:0]      avm_writedata,
    output logic [1:0]       avm_byteenable,
    input  logic             avm_waitrequest,
    output logic             Busy,
    output logic [CNT_W-1:0] Pixels_Written,
    output logic [CNT_W-1:0] Pixels_Dropped
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WRITE  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [31:0]       r_addr;
    logic [15:0]       r_data;
    logic              r_drop;
    logic [CNT_W-1:0]  r_written;
    logic [CNT_W-1:0]  r_dropped;

    logic [32:0]       w_offset;
    logic              w_in_win;

    // 33-bit compare keeps BASE+BYTES near the top of the address space from wrapping.
    assign w_offset = {1'b0, Pixel_Address} - {1'b0, BUF_BASE};
    assign w_in_win = ({1'b0, Pixel_Address} >= {1'b0, BUF_BASE}) &&
                      (w_offset < {1'b0, BUF_BYTES}) &&
                      !Pixel_Address[0];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (Draw) w_next = w_in_win ? S_WRITE : S_FINISH;
            S_WRITE:  if (!avm_waitrequest) w_next = S_FINISH;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_data    <= '0;
            r_drop    <= 1'b0;
            r_written <= '0;
            r_dropped <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (Draw) begin
                        r_addr <= Pixel_Address;
                        r_data <= Color;
                        r_drop <= !w_in_win;
                    end
                end
                S_WRITE: begin
                    if (!avm_waitrequest && (r_written != {CNT_W{1'b1}}))
                        r_written <= r_written + 1'b1;
                end
                S_FINISH: begin
                    if (r_drop && (r_dropped != {CNT_W{1'b1}}))
                        r_dropped <= r_dropped + 1'b1;
                    r_drop <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Strobes decode straight from state, so finish and write can never overlap.
    assign avm_write      = (r_state == S_WRITE);
    assign Write_Finish   = (r_state == S_FINISH);
    assign Busy           = (r_state != S_IDLE);
    assign avm_address    = r_addr;
    assign avm_writedata  = r_data;
    assign avm_byteenable = 2'b11;
    assign Pixels_Written = r_written;
    assign Pixels_Dropped = r_dropped;

endmodule

// File: tb/tb_pixel_write_responder.sv
// Directed bench for pixel_write_responder: per-cycle vector table plus
// hand-written stream, reset-abort and counter-saturation sequences.
module tb_pixel_write_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        Draw;
    logic [31:0] Pixel_Address;
    logic [15:0] Color;
    logic        Write_Finish;
    logic [31:0] avm_address;
    logic        avm_write;
    logic [15:0] avm_writedata;
    logic [1:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic        Busy;
    logic [3:0]  Pixels_Written;
    logic [3:0]  Pixels_Dropped;

    int n_pass = 0;
    int n_total = 0;

    pixel_write_responder #(
        .BUF_BASE (32'h0800_0000),
        .BUF_BYTES(32'd153600),
        .CNT_W    (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .Draw           (Draw),
        .Pixel_Address  (Pixel_Address),
        .Color          (Color),
        .Write_Finish   (Write_Finish),
        .avm_address    (avm_address),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_byteenable (avm_byteenable),
        .avm_waitrequest(avm_waitrequest),
        .Busy           (Busy),
        .Pixels_Written (Pixels_Written),
        .Pixels_Dropped (Pixels_Dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        logic        draw;
        logic [31:0] addr;
        logic [15:0] color;
        logic        ws;
        logic        e_wr;
        logic        e_fin;
        logic        e_busy;
        logic [31:0] e_addr;
        logic [15:0] e_data;
        logic [3:0]  e_pw;
        logic [3:0]  e_pd;
    } vec_t;

    vec_t vt [19];

    // Inputs are applied for the cycle before an edge; expectations are the state after it.
    task automatic do_write(input logic [31:0] a, input logic [15:0] c);
        int n;
        @(negedge clk);
        Draw = 1'b1; Pixel_Address = a; Color = c;
        @(negedge clk);
        Draw = 1'b0;
        n = 0;
        while (!Write_Finish && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("do_write_finish", {31'd0, Write_Finish}, 32'd1);
    endtask

    initial begin
        int edges, nfin, nwr, overlap;
        logic [31:0] base;

        vt[0]  = '{1'b1, 32'h0800_0010, 16'hF800, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0800_0010, 16'hF800, 4'd0, 4'd0};
        vt[1]  = '{1'b0, 32'h0000_0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        16'h0,    4'd1, 4'd0};
        vt[2]  = '{1'b0, 32'h0000_0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        16'h0,    4'd1, 4'd0};
        vt[3]  = '{1'b1, 32'h0800_0010, 16'hF800, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0800_0010, 16'hF800, 4'd1, 4'd0};
        vt[4]  = '{1'b0, 32'h0800_0100, 16'h001F, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0800_0010, 16'hF800, 4'd1, 4'd0};
        vt[5]  = '{1'b0, 32'h0800_0100, 16'h001F, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0800_0010, 16'hF800, 4'd1, 4'd0};
        vt[6]  = '{1'b0, 32'h0800_0100, 16'h001F, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0800_0010, 16'hF800, 4'd1, 4'd0};
        vt[7]  = '{1'b0, 32'h0800_0100, 16'h001F, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0800_0010, 16'hF800, 4'd1, 4'd0};
        vt[8]  = '{1'b0, 32'h0800_0100, 16'h001F, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        16'h0,    4'd2, 4'd0};
        vt[9]  = '{1'b0, 32'h0000_0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        16'h0,    4'd2, 4'd0};
        vt[10] = '{1'b1, 32'h0802_5800, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        16'h0,    4'd2, 4'd0};
        vt[11] = '{1'b1, 32'h0800_0003, 16'h5678, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        16'h0,    4'd2, 4'd1};
        vt[12] = '{1'b1, 32'h0800_0003, 16'h5678, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        16'h0,    4'd2, 4'd1};
        vt[13] = '{1'b0, 32'h0000_0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        16'h0,    4'd2, 4'd2};
        vt[14] = '{1'b1, 32'h0802_57FE, 16'h07E0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0802_57FE, 16'h07E0, 4'd2, 4'd2};
        vt[15] = '{1'b0, 32'h0000_0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        16'h0,    4'd3, 4'd2};
        vt[16] = '{1'b0, 32'h0000_0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        16'h0,    4'd3, 4'd2};
        vt[17] = '{1'b1, 32'h07FF_FFFE, 16'hAAAA, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        16'h0,    4'd3, 4'd2};
        vt[18] = '{1'b0, 32'h0000_0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        16'h0,    4'd3, 4'd3};

        reset = 1'b1; Draw = 1'b0; Pixel_Address = '0; Color = '0; avm_waitrequest = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_write",   {31'd0, avm_write},    32'd0);
        chk("rst_finish",  {31'd0, Write_Finish}, 32'd0);
        chk("rst_busy",    {31'd0, Busy},         32'd0);
        chk("rst_addr",    avm_address,           32'd0);
        chk("rst_data",    {16'd0, avm_writedata}, 32'd0);
        chk("rst_pw",      {28'd0, Pixels_Written}, 32'd0);
        chk("rst_pd",      {28'd0, Pixels_Dropped}, 32'd0);
        chk("byteenable",  {30'd0, avm_byteenable}, 32'd3);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            Draw = vt[i].draw; Pixel_Address = vt[i].addr;
            Color = vt[i].color; avm_waitrequest = vt[i].ws;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_write", i),  {31'd0, avm_write},    {31'd0, vt[i].e_wr});
            chk($sformatf("v%0d_finish", i), {31'd0, Write_Finish}, {31'd0, vt[i].e_fin});
            chk($sformatf("v%0d_busy", i),   {31'd0, Busy},         {31'd0, vt[i].e_busy});
            chk($sformatf("v%0d_pw", i),     {28'd0, Pixels_Written}, {28'd0, vt[i].e_pw});
            chk($sformatf("v%0d_pd", i),     {28'd0, Pixels_Dropped}, {28'd0, vt[i].e_pd});
            if (vt[i].e_wr) begin
                chk($sformatf("v%0d_addr", i), avm_address, vt[i].e_addr);
                chk($sformatf("v%0d_data", i), {16'd0, avm_writedata}, {16'd0, vt[i].e_data});
            end
        end

        // Back-to-back stream: Draw held, requester advances on each Write_Finish.
        base = 32'h0800_0200;
        @(negedge clk);
        Draw = 1'b1; Pixel_Address = base; Color = 16'h1000; avm_waitrequest = 1'b0;
        edges = 0; nfin = 0; nwr = 0; overlap = 0;
        while (nfin < 10 && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            if (avm_write && Write_Finish) overlap++;
            if (avm_write) begin
                chk($sformatf("stream_addr%0d", nwr), avm_address, base + 32'(2 * nwr));
                chk($sformatf("stream_data%0d", nwr), {16'd0, avm_writedata}, 32'h1000 + 32'(nwr));
                nwr++;
            end
            if (Write_Finish) begin
                nfin++;
                if (nfin == 10) Draw = 1'b0;
                else begin
                    Pixel_Address = base + 32'(2 * nfin);
                    Color = 16'h1000 + 16'(nfin);
                end
            end
        end
        chk("stream_edges",   32'(edges),   32'd29);
        chk("stream_writes",  32'(nwr),     32'd10);
        chk("stream_finish",  32'(nfin),    32'd10);
        chk("stream_overlap", 32'(overlap), 32'd0);
        @(posedge clk);
        #1;
        chk("stream_idle", {31'd0, Busy}, 32'd0);
        chk("stream_pw",   {28'd0, Pixels_Written}, 32'd13);

        // Reset while stalled in WRITE abandons the bus write.
        @(negedge clk);
        Draw = 1'b1; Pixel_Address = 32'h0800_0400; Color = 16'hBEEF; avm_waitrequest = 1'b1;
        @(negedge clk);
        Draw = 1'b0;
        chk("pre_rst_write", {31'd0, avm_write}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_write",  {31'd0, avm_write},    32'd0);
        chk("mid_rst_busy",   {31'd0, Busy},         32'd0);
        chk("mid_rst_finish", {31'd0, Write_Finish}, 32'd0);
        chk("mid_rst_pw",     {28'd0, Pixels_Written}, 32'd0);
        chk("mid_rst_pd",     {28'd0, Pixels_Dropped}, 32'd0);
        @(negedge clk);
        reset = 1'b0; avm_waitrequest = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_finish", {31'd0, Write_Finish}, 32'd0);
        chk("post_rst_busy",   {31'd0, Busy},         32'd0);

        do_write(32'h0800_0020, 16'h00FF);
        @(posedge clk);
        #1;
        chk("post_rst_pw", {28'd0, Pixels_Written}, 32'd1);

        // 16 more writes: 17 since reset, counter must stick at 4'hF.
        for (int k = 0; k < 16; k++) begin
            do_write(32'h0800_0040 + 32'(2 * k), 16'(k));
            if (k == 13) begin
                @(posedge clk);
                #1;
                chk("sat_reach_pw", {28'd0, Pixels_Written}, 32'd15);
            end
        end
        @(posedge clk);
        #1;
        chk("sat_pw", {28'd0, Pixels_Written}, 32'd15);
        chk("sat_pd", {28'd0, Pixels_Dropped}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
